// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared encodings and helpers for the RV32M multiply/divide sequencer
package muldiv_sequencer_pkg;

    localparam int XLEN = 32;
    localparam logic [4:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        FN_MUL    = 3'b000,
        FN_MULH   = 3'b001,
        FN_MULHSU = 3'b010,
        FN_MULHU  = 3'b011,
        FN_DIV    = 3'b100,
        FN_DIVU   = 3'b101,
        FN_REM    = 3'b110,
        FN_REMU   = 3'b111
    } funct_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - EX-stage request/response bundle between pipeline and muldiv sequencer
interface muldiv_sequencer_if;

    logic                                    start;
    logic [2:0]                              function3;
    logic [muldiv_sequencer_pkg::XLEN-1:0]   op_a;
    logic [muldiv_sequencer_pkg::XLEN-1:0]   op_b;
    logic                                    kill;
    logic                                    busy;
    logic                                    stall;
    logic                                    done;
    logic [muldiv_sequencer_pkg::XLEN-1:0]   result;

    modport master (
        output start, function3, op_a, op_b, kill,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, function3, op_a, op_b, kill,
        output busy, stall, done, result
    );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational radix-2 iteration: shift-add multiply or restoring divide
// Divider half exists only when MULDIV_DIV_EN is defined.
module muldiv_step (
    input  logic [63:0] acc_i,
    input  logic [31:0] operand_i,
    input  logic        div_sel_i,
    output logic [63:0] acc_o
);

    logic [32:0] add_sum;

    // Low half holds the unconsumed multiplier bits; the carry re-enters at bit 63 on the shift.
    always_comb begin
        add_sum = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);
    end

`ifdef MULDIV_DIV_EN
    logic [32:0] rem_shift;
    logic [31:0] diff_lo;
    logic        fits;

    // Remainder is always below the divisor, so a successful subtract fits in 32 bits.
    always_comb begin
        rem_shift = acc_i[63:31];
        fits      = rem_shift >= {1'b0, operand_i};
        diff_lo   = rem_shift[31:0] - operand_i;
        if (!div_sel_i) begin
            acc_o = {add_sum, acc_i[31:1]};
        end else if (fits) begin
            acc_o = {diff_lo, acc_i[30:0], 1'b1};
        end else begin
            acc_o = {rem_shift[31:0], acc_i[30:0], 1'b0};
        end
    end
`else
    always_comb begin
        acc_o = div_sel_i ? 64'd0 : {add_sum, acc_i[31:1]};
    end
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M mul/div controller with pipeline stall and done pulse
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    funct_e      fn_q, fn_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d;

    funct_e      fn_in;
    logic        accept;
    logic        is_div_in;
    logic        signed_a, signed_b;
    logic        neg_a, neg_b;
    logic [31:0] a_mag, b_mag;
    logic [63:0] step_acc;
    logic [63:0] prod_fix;
    logic [31:0] fix_value;

    muldiv_step u_step (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .div_sel_i (fn_q[2]),
        .acc_o     (step_acc)
    );

    always_comb begin
        fn_in     = funct_e'(bus.function3);
        is_div_in = bus.function3[2];
        accept    = (state_q == ST_IDLE) && bus.start && !bus.kill;
        signed_a  = (fn_in != FN_MULHU) && (fn_in != FN_DIVU) && (fn_in != FN_REMU);
        signed_b  = signed_a && (fn_in != FN_MULHSU);
        neg_a     = signed_a && bus.op_a[31];
        neg_b     = signed_b && bus.op_b[31];
        a_mag     = neg_a ? neg32(bus.op_a) : bus.op_a;
        b_mag     = neg_b ? neg32(bus.op_b) : bus.op_b;
    end

    always_comb begin
        prod_fix  = sign_q ? neg64(acc_q) : acc_q;
        fix_value = 32'd0;
        case (fn_q)
            FN_MUL:                        fix_value = prod_fix[31:0];
            FN_MULH, FN_MULHSU, FN_MULHU:  fix_value = prod_fix[63:32];
`ifdef MULDIV_DIV_EN
            FN_DIV, FN_DIVU:  fix_value = sign_q ? neg32(acc_q[31:0])  : acc_q[31:0];
            FN_REM, FN_REMU:  fix_value = sign_q ? neg32(acc_q[63:32]) : acc_q[63:32];
`endif
            default:                       fix_value = 32'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        fn_d     = fn_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        sign_d   = sign_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    fn_d    = fn_in;
                    state_d = ST_CALC;
                    count_d = ITER_LAST;
                    acc_d   = {32'd0, a_mag};
                    opnd_d  = b_mag;
                    // Remainder follows the dividend; everything else follows the operand xor.
                    sign_d  = (is_div_in && bus.function3[1]) ? neg_a : (neg_a ^ neg_b);
`ifdef MULDIV_DIV_EN
                    if (is_div_in && (bus.op_b == 32'd0)) begin
                        state_d  = ST_DONE;
                        result_d = bus.function3[1] ? bus.op_a : 32'hFFFF_FFFF;
                    end else if (is_div_in && !bus.function3[0] &&
                                 (bus.op_a == 32'h8000_0000) && (bus.op_b == 32'hFFFF_FFFF)) begin
                        state_d  = ST_DONE;
                        result_d = bus.function3[1] ? 32'd0 : 32'h8000_0000;
                    end
`else
                    if (is_div_in) begin
                        state_d  = ST_DONE;
                        result_d = 32'd0;
                    end
`endif
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                if (count_q == 5'd0) begin
                    state_d = ST_FIX;
                end else begin
                    count_d = count_q - 5'd1;
                end
            end
            ST_FIX: begin
                result_d = fix_value;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush drops the in-flight op without touching the visible result.
        if (bus.kill && ((state_q == ST_CALC) || (state_q == ST_FIX))) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= 5'd0;
            fn_q     <= FN_MUL;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            fn_q     <= fn_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.stall  = ((state_q == ST_IDLE) && bus.start) || busy_q;
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;

endmodule
